// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial ripple adder. A load strobe captures DA, DB and Cin1; the sum
// DA + DB + Cin1 is then formed one bit per clock, LSB first, by a single
// full-adder cell. After WIDTH shift cycles the result sits in Sum, the final
// carry in Cout, and done is raised.
//
// Handshake: done acts as a valid flag with no ready. It is low during reset,
// on the load edge and while shifting. It rises on the final shift edge and
// stays high, with Sum/Cout held, until the next load or reset. A consumer
// qualifies Sum/Cout with done; intermediate values are partial.
//
// Ports:
//   clock     in   rising-edge clock
//   reset_n   in   synchronous active-low reset (priority over load)
//   load      in   capture operands and start or restart an add
//   DA, DB    in   WIDTH-bit operands, sampled only when load=1
//   Cin1      in   carry-in, sampled only when load=1
//   Sum       out  WIDTH-bit result register
//   Cout      out  carry register / final carry-out
//   done      out  completed result held
//   fsm_state out  debug view of the FSM state (0 = IDLE, 1 = SHIFT)
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] DA,
    input  logic [WIDTH-1:0] DB,
    input  logic             Cin1,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             done,
    output logic             fsm_state
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [CNT_W-1:0]   count;
    logic               last_bit;
    logic               sum_bit;
    logic               carry_next;

    // The last shift happens when the counter reaches WIDTH-1, so the
    // counter never wraps.
    assign last_bit   = (count == CNT_W'(WIDTH - 1));

    // Single full-adder cell working on the LSBs of the operand registers.
    assign sum_bit    = a_reg[0] ^ b_reg[0] ^ Cout;
    assign carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & Cout) | (b_reg[0] & Cout);

    assign fsm_state  = state;

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: load restarts from any state.
    always_comb begin
        state_next = state;
        if (load) begin
            state_next = SHIFT;
        end else if (state == SHIFT && last_bit) begin
            state_next = IDLE;
        end
    end

    // Datapath
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            a_reg <= '0;
            b_reg <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
            count <= '0;
            done  <= 1'b0;
        end else if (load) begin
            a_reg <= DA;
            b_reg <= DB;
            Cout  <= Cin1;
            Sum   <= '0;
            count <= '0;
            done  <= 1'b0;
        end else if (state == SHIFT) begin
            a_reg <= a_reg >> 1;
            b_reg <= b_reg >> 1;
            Sum   <= {sum_bit, Sum[WIDTH-1:1]};
            Cout  <= carry_next;
            count <= count + 1'b1;
            if (last_bit) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Directed test of serial_adder (WIDTH = 8). The driver pushes the
// hand-computed {Cout, Sum} of each add into exp_q when it issues the load;
// the monitor pops and compares on every rising edge of done.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic         clock = 1'b0;
    logic         reset_n;
    logic         load;
    logic [W-1:0] DA;
    logic [W-1:0] DB;
    logic         Cin1;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         done;
    logic         fsm_state;

    always #5 clock = ~clock;

    serial_adder #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (load),
        .DA        (DA),
        .DB        (DB),
        .Cin1      (Cin1),
        .Sum       (Sum),
        .Cout      (Cout),
        .done      (done),
        .fsm_state (fsm_state)
    );

    // ---------------- scoreboard ----------------
    logic [W:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each completed result against the queue head.
    logic done_prev = 1'b0;
    always @(negedge clock) begin
        if (done === 1'b1 && done_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 with Sum=0x%0h Cout=%0b, expected no result", Sum, Cout);
            end else begin
                check("result", {Cout, Sum}, exp_q.pop_front());
            end
        end
        done_prev = done;
    end

    // ---------------- driver tasks ----------------
    // All tasks are entered and left just after a falling edge.
    task automatic issue_load(input logic [W-1:0] da, input logic [W-1:0] db, input logic cin);
        load = 1'b1;
        DA   = da;
        DB   = db;
        Cin1 = cin;
        @(posedge clock);
        @(negedge clock);
        load = 1'b0;
        DA   = $urandom_range(0, 255);
        DB   = $urandom_range(0, 255);
        Cin1 = 1'($urandom_range(0, 1));
    endtask

    task automatic shift_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    // Bounded wait for completion: done must be low after 7 shift edges and
    // high after the 8th.
    task automatic wait_done(input string name);
        shift_edges(W - 1);
        check({name, "_done_early"}, {8'h00, done}, 9'h000);
        shift_edges(1);
        check({name, "_done_latency"}, {8'h00, done}, 9'h001);
    endtask

    task automatic add(input string name, input logic [W-1:0] da, input logic [W-1:0] db,
                       input logic cin, input logic [W:0] exp);
        exp_q.push_back(exp);
        issue_load(da, db, cin);
        wait_done(name);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0;
        load    = 1'b1;
        DA      = 8'hAA;
        DB      = 8'h55;
        Cin1    = 1'b1;

        // Reset with load high for two edges: reset wins.
        shift_edges(2);
        check("reset_sum_cout", {Cout, Sum}, 9'h000);
        check("reset_done", {8'h00, done}, 9'h000);
        check("reset_state", {8'h00, fsm_state}, 9'h000);
        load    = 1'b0;
        reset_n = 1'b1;
        shift_edges(2);
        check("idle_no_load_done", {8'h00, done}, 9'h000);

        // Basic add then hold for 5 edges.
        add("basic", 8'h0A, 8'h0F, 1'b0, 9'h019);
        for (int i = 0; i < 5; i++) begin
            shift_edges(1);
            check("hold_result", {Cout, Sum}, 9'h019);
            check("hold_done", {8'h00, done}, 9'h001);
        end
        check("idle_state", {8'h00, fsm_state}, 9'h000);

        // Carry chain and carry-in cases.
        add("wrap_ff_01",    8'hFF, 8'h01, 1'b0, 9'h100);
        add("wrap_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
        add("cin_only",      8'h00, 8'h00, 1'b1, 9'h001);
        add("cin_7f",        8'h7F, 8'h00, 1'b1, 9'h080);
        add("a5_5a_c1",      8'hA5, 8'h5A, 1'b1, 9'h100);

        // Restart mid-add: the first add is abandoned.
        exp_q.push_back(9'h019);
        issue_load(8'h0A, 8'h0F, 1'b0);
        shift_edges(3);
        check("restart_busy_done", {8'h00, done}, 9'h000);
        void'(exp_q.pop_back());
        add("restart", 8'h80, 8'h80, 1'b0, 9'h100);

        // Load held for several edges: only the last operands count.
        load = 1'b1;
        DA = 8'h01; DB = 8'h02; Cin1 = 1'b1;
        shift_edges(1);
        DA = 8'h03; DB = 8'h04; Cin1 = 1'b0;
        shift_edges(1);
        check("held_load_done", {8'h00, done}, 9'h000);
        add("held_load", 8'h10, 8'h20, 1'b0, 9'h030);

        // Reset mid-add: no result may appear afterwards.
        exp_q.push_back(9'h088);
        issue_load(8'h55, 8'h33, 1'b0);
        shift_edges(4);
        void'(exp_q.pop_back());
        reset_n = 1'b0;
        shift_edges(1);
        check("midreset_sum_cout", {Cout, Sum}, 9'h000);
        check("midreset_done", {8'h00, done}, 9'h000);
        reset_n = 1'b1;
        shift_edges(12);
        check("midreset_no_done", {8'h00, done}, 9'h000);
        check("midreset_state", {8'h00, fsm_state}, 9'h000);

        // Every pushed result must have been seen.
        check("queue_empty", 9'(exp_q.size()), 9'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
